program_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle core. It receives a byte stream over a valid/ready link and assembles big-endian 32-bit words. It writes the program into the instruction memory write port, verifies an XOR checksum, then releases the core by driving the start PC and asserting run. The core must not be clocked through instructions while `core_run` is low.

---
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes them to
// instruction memory, verifies an XOR checksum and releases the core.
module program_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [31:0] init_pc,
  output logic        core_run,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_PC, S_LEN, S_PAY, S_CHK, S_RUN, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_shift;
  logic [7:0]  r_csum;
  logic [31:0] r_pc;
  logic [15:0] r_len;
  logic [15:0] r_words;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_init_pc;

  logic        w_acc;
  logic        w_last;
  logic [31:0] w_word;
  logic        w_len_bad;
  logic        w_pay_done;
  logic        w_restart;
  logic        w_cs_ok;

  assign w_acc      = in_valid && in_ready;
  assign w_last     = w_acc && (r_cnt == 2'd3);
  assign w_word     = {r_shift[23:0], in_data};
  assign w_len_bad  = (w_word == 32'd0) ||
                      (w_word > 32'(MAX_WORDS));
  assign w_pay_done = (r_words + 16'd1) == r_len;
  assign w_restart  = restart &&
                      (r_state == S_RUN || r_state == S_ERR);
  assign w_cs_ok    = (in_data == r_csum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_PC;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_PC:
        if (w_last)
          w_next = (w_word[1:0] != 2'b00) ? S_ERR : S_LEN;
      S_LEN:
        if (w_last) w_next = w_len_bad ? S_ERR : S_PAY;
      S_PAY:
        if (w_last && w_pay_done) w_next = S_CHK;
      S_CHK:
        if (w_acc) w_next = w_cs_ok ? S_RUN : S_ERR;
      S_RUN, S_ERR:
        if (restart) w_next = S_PC;
      default:
        w_next = S_PC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_csum    <= '0;
      r_pc      <= '0;
      r_len     <= '0;
      r_words   <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_init_pc <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_restart) begin
        r_cnt     <= '0;
        r_shift   <= '0;
        r_csum    <= '0;
        r_pc      <= '0;
        r_len     <= '0;
        r_words   <= '0;
        r_init_pc <= '0;
      end else if (w_acc) begin
        // checksum byte is compared, not folded in
        if (r_state != S_CHK) begin
          r_cnt   <= r_cnt + 2'd1;
          r_shift <= w_word;
          r_csum  <= r_csum ^ in_data;
        end
        if (w_last) begin
          unique case (1'b1)
            (r_state == S_PC): r_pc <= w_word;
            (r_state == S_LEN): begin
              if (!w_len_bad) r_len <= w_word[15:0];
            end
            (r_state == S_PAY): begin
              r_we    <= 1'b1;
              r_addr  <= r_pc + {14'd0, r_words, 2'b00};
              r_wdata <= w_word;
              r_words <= r_words + 16'd1;
            end
            default: ;
          endcase
        end
        if (r_state == S_CHK && w_cs_ok)
          r_init_pc <= r_pc;
      end
    end
  end

  assign in_ready     = (r_state == S_PC)  ||
                        (r_state == S_LEN) ||
                        (r_state == S_PAY) ||
                        (r_state == S_CHK);
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign init_pc      = r_init_pc;
  assign core_run     = (r_state == S_RUN);
  assign error        = (r_state == S_ERR);
  assign words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Randomized frame bench for program_loader with a frame-level
// reference model and a write scoreboard.
module tb_program_loader;

  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] init_pc;
  logic        core_run;
  logic        error;
  logic [15:0] words_loaded;

  program_loader #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .restart(restart),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .init_pc(init_pc),
    .core_run(core_run), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0]  fr[$];
  logic [63:0] exp_q[$];
  int          m_cons;
  logic        m_run, m_err;
  logic [31:0] m_pc, m_words;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // scoreboard for memory writes
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", {31'd0, imem_we}, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("waddr", imem_addr, e[63:32]);
        chk("wdata", imem_wdata, e[31:0]);
      end
    end
  end

  // frame-level model: parse fr, queue expected writes
  task automatic model();
    logic [31:0] pc, n, w;
    logic [7:0]  cs;
    m_run = 0; m_err = 0; m_words = 0;
    pc = {fr[0], fr[1], fr[2], fr[3]};
    m_pc = pc; m_cons = 4;
    if (pc % 4 != 0) begin m_err = 1; return; end
    n = {fr[4], fr[5], fr[6], fr[7]};
    m_cons = 8;
    if (n == 0 || n > MAXW) begin m_err = 1; return; end
    for (int i = 0; i < int'(n); i++) begin
      w = {fr[8+4*i], fr[9+4*i], fr[10+4*i], fr[11+4*i]};
      exp_q.push_back({pc + 32'(4 * i), w});
    end
    m_words = n;
    cs = 0;
    for (int i = 0; i < 8 + 4 * int'(n); i++) cs ^= fr[i];
    m_cons = 9 + 4 * int'(n);
    if (fr[m_cons-1] == cs) m_run = 1;
    else m_err = 1;
  endtask

  task automatic build(input logic [31:0] pc,
                       input logic [31:0] n,
                       input logic [7:0] bad);
    logic [7:0] cs;
    logic [31:0] w;
    fr.delete();
    for (int k = 3; k >= 0; k--) fr.push_back(pc[8*k +: 8]);
    for (int k = 3; k >= 0; k--) fr.push_back(n[8*k +: 8]);
    if (n != 0 && n <= MAXW) begin
      for (int i = 0; i < int'(n); i++) begin
        w = $urandom;
        for (int k = 3; k >= 0; k--) fr.push_back(w[8*k +: 8]);
      end
      cs = 0;
      foreach (fr[i]) cs ^= fr[i];
      fr.push_back(cs ^ bad);
    end
  endtask

  // called just after a negedge; returns just after the next
  // negedge following the accepting edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    while (gap > 0 && $urandom_range(99) < gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("rdy_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int gap);
    model();
    for (int i = 0; i < m_cons; i++) send_byte(fr[i], gap);
    in_valid = 1'b0;
    chk("run", {31'd0, core_run}, {31'd0, m_run});
    chk("err", {31'd0, error}, {31'd0, m_err});
    chk("rdy_end", {31'd0, in_ready}, 32'd0);
    chk("words", {16'd0, words_loaded}, m_words);
    if (m_run) chk("init_pc", init_pc, m_pc);
    chk("wr_left", exp_q.size(), 32'd0);
  endtask

  task automatic do_restart();
    restart  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    chk("rst_rdy0", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;
    chk("rs_run", {31'd0, core_run}, 32'd0);
    chk("rs_err", {31'd0, error}, 32'd0);
    chk("rs_rdy", {31'd0, in_ready}, 32'd1);
    chk("rs_words", {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({p, "_addr"}, imem_addr, 32'd0);
    chk({p, "_wdata"}, imem_wdata, 32'd0);
    chk({p, "_pc"}, init_pc, 32'd0);
    chk({p, "_run"}, {31'd0, core_run}, 32'd0);
    chk({p, "_err"}, {31'd0, error}, 32'd0);
    chk({p, "_words"}, {16'd0, words_loaded}, 32'd0);
    chk({p, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic nominal();
    fr = {8'h00, 8'h00, 8'h00, 8'h40,
          8'h00, 8'h00, 8'h00, 8'h02,
          8'h20, 8'h08, 8'h00, 8'h05,
          8'h00, 8'h00, 8'h00, 8'h00, 8'h6F};
  endtask

  initial begin
    #3;
    chk_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // fixed nominal frame with independent expectations
    nominal();
    model();
    chk("nom_model_run", {31'd0, m_run}, 32'd1);
    exp_q.delete();
    exp_q.push_back({32'h40, 32'h20080005});
    exp_q.push_back({32'h44, 32'h00000000});
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i], 0);
    in_valid = 1'b0;
    chk("nom_run", {31'd0, core_run}, 32'd1);
    chk("nom_pc", init_pc, 32'h40);
    chk("nom_words", {16'd0, words_loaded}, 32'd2);
    chk("nom_rdy", {31'd0, in_ready}, 32'd0);
    chk("nom_wr_left", exp_q.size(), 32'd0);
    do_restart();

    // backpressure
    nominal();
    send_frame(50);
    do_restart();

    // bad checksum
    nominal();
    fr[16] = 8'h6E;
    send_frame(0);
    chk("badcs_err", {31'd0, error}, 32'd1);
    do_restart();

    // header rejects
    build(32'h40, 32'd0, 8'h00);
    send_frame(0);
    do_restart();
    build(32'h40, 32'd257, 8'h00);
    send_frame(0);
    do_restart();
    build(32'h42, 32'd2, 8'h00);
    send_frame(0);
    do_restart();
    build(32'h40, 32'd256, 8'h00);
    send_frame(0);
    do_restart();

    // reset with a write pending
    nominal();
    exp_q.delete();
    exp_q.push_back({32'h40, 32'h20080005});
    for (int i = 0; i < 12; i++) send_byte(fr[i], 0);
    in_valid = 1'b0;
    chk("pend_we", {31'd0, imem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    nominal();
    send_frame(0);
    do_restart();

    // second frame at 0x80
    build(32'h80, 32'd3, 8'h00);
    send_frame(0);
    chk("pc80", init_pc, 32'h80);
    do_restart();

    // random frames
    for (int f = 0; f < 30; f++) begin
      logic [31:0] pc, n;
      logic [7:0] bad;
      pc  = $urandom & 32'hFFFF_FFFC;
      n   = 32'($urandom_range(1, 6));
      bad = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      case ($urandom_range(5))
        0: pc = 32'hFFFF_FFF8;
        1: pc = pc | 32'($urandom_range(1, 3));
        2: n  = ($urandom_range(1) == 0) ? 32'd0 : 32'd300;
        default: ;
      endcase
      build(pc, n, bad);
      send_frame($urandom_range(1) == 0 ? 0 : 40);
      do_restart();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
